// File: rtl/audio_channel_player.sv
// Audio output stage: channel select, click-free volume ramp, PWM pin pair and level meter.
// Define PEAK_HOLD_EN to add peak-hold with per-segment decay to the meter.
module audio_channel_player #(
  parameter int CHANNELS     = 6,
  parameter int WIDTH        = 16,
  parameter int VOL_WIDTH    = 10,
  parameter int PWM_BITS     = 8,
  parameter int LEVELS       = 10,
  parameter int HOLD_SAMPLES = 4800
) (
  input  logic                      Clk,
  input  logic                      nReset,
  input  logic                      Sample_Ena,
  input  logic                      Data_Clk,
  input  logic [CHANNELS*WIDTH-1:0] Audio,
  input  logic [3:0]                Channel,
  input  logic [VOL_WIDTH-1:0]      Volume,
  input  logic                      Mute,
  output logic [WIDTH-1:0]          DemuxSound,
  output logic [1:0]                PWM,
  output logic [LEVELS-1:0]         Level
);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MAX_POS  = {1'b0, {(WIDTH-1){1'b1}}};

  // [0],[1] synchronise Data_Clk, [2] is the history bit for edge detection
  logic [2:0]           dclk_sync;
  logic                 frame_edge;
  logic [WIDTH-1:0]     sel_sample;
  logic [VOL_WIDTH-1:0] vol_cur, vol_tgt;
  logic                 sign;
  logic [WIDTH-1:0]     mag, scaled_mag, scaled, scaled_nxt;
  logic [WIDTH+VOL_WIDTH-1:0] prod;
  logic [PWM_BITS-1:0]  pwm_cnt, duty, duty_q;
  logic [LEVELS-1:0]    inst, inst_q;
  logic                 scaled_unused;

  assign frame_edge = dclk_sync[2] ^ dclk_sync[1];

  always_comb begin
    sel_sample = '0;
    for (int k = 0; k < CHANNELS; k++)
      if (Channel == 4'(k)) sel_sample = Audio[k*WIDTH +: WIDTH];
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      dclk_sync  <= '0;
      DemuxSound <= '0;
    end else begin
      dclk_sync <= {dclk_sync[1:0], Data_Clk};
      if (frame_edge) DemuxSound <= sel_sample;
    end
  end

  assign vol_tgt = Mute ? '0 : Volume;

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset)                          vol_cur <= '0;
    else if (Sample_Ena && vol_cur < vol_tgt) vol_cur <= vol_cur + 1'b1;
    else if (Sample_Ena && vol_cur > vol_tgt) vol_cur <= vol_cur - 1'b1;
  end

  // Sign-magnitude scaling keeps the ramp symmetric; most-negative saturates
  assign sign       = DemuxSound[WIDTH-1];
  assign mag        = !sign ? DemuxSound : (DemuxSound == MOST_NEG) ? MAX_POS : -DemuxSound;
  assign prod       = {{VOL_WIDTH{1'b0}}, mag} * {{WIDTH{1'b0}}, vol_cur};
  assign scaled_mag = WIDTH'(prod >> VOL_WIDTH);
  assign scaled_nxt = sign ? -scaled_mag : scaled_mag;

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset)         scaled <= '0;
    else if (Sample_Ena) scaled <= scaled_nxt;
  end

  assign duty          = {~scaled[WIDTH-1], scaled[WIDTH-2 -: PWM_BITS-1]};
  assign scaled_unused = ^scaled[WIDTH-PWM_BITS-1:0];

  // Duty only reloads at period wrap so a period is never cut short
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      pwm_cnt <= '0;
      duty_q  <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      if (&pwm_cnt) duty_q <= duty;
    end
  end

  assign PWM = {2{pwm_cnt < duty_q}};

  for (genvar k = 0; k < LEVELS; k++) begin : g_seg
    localparam logic [WIDTH-1:0] THR = WIDTH'(1) << (WIDTH-2-k);
    assign inst[k] = (mag >= THR);
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset)         inst_q <= '0;
    else if (Sample_Ena) inst_q <= inst;
  end

`ifdef PEAK_HOLD_EN
  localparam int TW = $clog2(HOLD_SAMPLES+1);
  localparam logic [TW-1:0] HOLD_INIT = TW'(HOLD_SAMPLES);

  logic [LEVELS-1:0] held;
  logic [TW-1:0]     hold_timer;

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      held       <= '0;
      hold_timer <= '0;
    end else if (Sample_Ena) begin
      if ($countones(inst) >= $countones(held)) begin
        held       <= inst;
        hold_timer <= HOLD_INIT;
      end else if (hold_timer != '0) begin
        hold_timer <= hold_timer - 1'b1;
      end else begin
        held       <= held << 1;
        hold_timer <= HOLD_INIT;
      end
    end
  end

  assign Level = held | inst_q;
`else
  assign Level = inst_q;
`endif

endmodule

// File: tb/tb_audio_channel_player.sv
// Self-checking bench for audio_channel_player: vector table, hand sequences and a randomized model run.
module tb_audio_channel_player;
  localparam int CH = 6, W = 16, VW = 10, PB = 8, LV = 10, HOLD = 12;

  logic          Clk = 0, nReset = 1, Sample_Ena = 0, Data_Clk = 0, Mute = 0;
  logic [CH*W-1:0] Audio = '0;
  logic [3:0]    Channel = '0;
  logic [VW-1:0] Volume = '0;
  logic [W-1:0]  DemuxSound;
  logic [1:0]    PWM;
  logic [LV-1:0] Level;

  int checks = 0, failures = 0;

  // reference model state
  logic [W-1:0]  m_demux = '0;
  int            m_vol = 0, m_scaled = 0, m_held = 0, m_timer = 0;
  logic [LV-1:0] m_level = '0;

  audio_channel_player #(.CHANNELS(CH), .WIDTH(W), .VOL_WIDTH(VW), .PWM_BITS(PB),
                         .LEVELS(LV), .HOLD_SAMPLES(HOLD)) dut (
    .Clk(Clk), .nReset(nReset), .Sample_Ena(Sample_Ena), .Data_Clk(Data_Clk),
    .Audio(Audio), .Channel(Channel), .Volume(Volume), .Mute(Mute),
    .DemuxSound(DemuxSound), .PWM(PWM), .Level(Level));

  always #5 Clk = ~Clk;

  typedef struct {
    int            ch;
    logic [W-1:0]  s;
    logic [W-1:0]  exp_demux;
    logic [LV-1:0] exp_level;
  } vec_t;
  vec_t tab[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, $signed(act), $signed(exp));
    end
  endtask

  function automatic int mag_of(input logic [W-1:0] s);
    int v = $signed(s);
    if (v < 0) v = -v;
    if (v > (1 << (W-1)) - 1) v = (1 << (W-1)) - 1;
    return v;
  endfunction

  // number of 6 dB segments lit: quietest threshold doubles per segment
  function automatic int segs(input int mag);
    int n = 0;
    int t = 1 << (W-2-(LV-1));
    while (n < LV && mag >= t) begin n++; t = t * 2; end
    return n;
  endfunction

  function automatic logic [LV-1:0] therm(input int n);
    logic [LV-1:0] r = '0;
    for (int i = 0; i < n; i++) r[LV-1-i] = 1'b1;
    return r;
  endfunction

  function automatic void model_sample();
    int mag = mag_of(m_demux);
    int sm  = (mag * m_vol) >> VW;
    int ni  = segs(mag);
    int tgt = Mute ? 0 : int'(Volume);
    m_scaled = m_demux[W-1] ? -sm : sm;
`ifdef PEAK_HOLD_EN
    if (ni >= m_held) begin m_held = ni; m_timer = HOLD; end
    else if (m_timer != 0) m_timer--;
    else begin m_held--; m_timer = HOLD; end
    m_level = therm(ni > m_held ? ni : m_held);
`else
    m_level = therm(ni);
`endif
    if (m_vol < tgt) m_vol++;
    else if (m_vol > tgt) m_vol--;
  endfunction

  task automatic tick();
    @(posedge Clk); #1;
  endtask

  task automatic pulse();
    Sample_Ena = 1;
    @(posedge Clk); model_sample(); #1;
    Sample_Ena = 0;
  endtask

  task automatic capture(input int ch, input logic [W-1:0] s);
    Channel = 4'(ch);
    if (ch < CH) Audio[ch*W +: W] = s;
    Data_Clk = ~Data_Clk;
    tick(); tick();
    chk("cap_early", DemuxSound, m_demux);
    tick();
    m_demux = (ch < CH) ? s : '0;
    chk("cap", DemuxSound, m_demux);
  endtask

  task automatic measure(output int hi);
    repeat (512) tick();
    hi = 0;
    repeat (256) begin tick(); if (PWM == 2'b11) hi++; end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi, n;
    logic prev;
    bit found;
    tab[0]  = '{3,  16'h1234, 16'h1234, 10'b1111111100};
    tab[1]  = '{7,  16'h5555, 16'h0000, 10'b0000000000};
    tab[2]  = '{0,  16'd300,  16'd300,  10'b1111000000};
    tab[3]  = '{1,  16'd16384,16'd16384,10'b1111111111};
    tab[4]  = '{2,  16'd16383,16'd16383,10'b1111111110};
    tab[5]  = '{4,  16'hFED4, 16'hFED4, 10'b1111000000};
    tab[6]  = '{5,  16'h8000, 16'h8000, 10'b1111111111};
    tab[7]  = '{0,  16'd31,   16'd31,   10'b0000000000};
    tab[8]  = '{5,  16'd32,   16'd32,   10'b1000000000};
    tab[9]  = '{2,  16'hFFE0, 16'hFFE0, 10'b1000000000};
    tab[10] = '{15, 16'h7FFF, 16'h0000, 10'b0000000000};

    // reset state
    #2 nReset = 0;
    #1;
    chk("rst_demux", DemuxSound, 0);
    chk("rst_pwm", PWM, 0);
    chk("rst_level", Level, 0);
    tick(); tick();
    nReset = 1;
    tick();

    // capture and meter vectors
    foreach (tab[i]) begin
      capture(tab[i].ch, tab[i].s);
      chk("vec_demux", DemuxSound, tab[i].exp_demux);
      pulse();
`ifdef PEAK_HOLD_EN
      chk("vec_level", Level, m_level);
`else
      chk("vec_level", Level, tab[i].exp_level);
`endif
    end

    // a channel change with no frame edge must not reload
    Channel = 4'd3;
    repeat (6) tick();
    chk("chan_only", DemuxSound, 0);

    // volume ramp
    Volume = 10'd1023;
    repeat (1022) pulse();
    chk("ramp_1022", dut.vol_cur, 1022);
    pulse(); chk("ramp_1023", dut.vol_cur, 1023);
    pulse(); chk("ramp_hold", dut.vol_cur, 1023);
    Mute = 1;
    repeat (1022) pulse();
    chk("mute_1", dut.vol_cur, 1);
    pulse(); chk("mute_0", dut.vol_cur, 0);
    Mute = 0;
    repeat (500) pulse();
    chk("up_500", dut.vol_cur, 500);
    Mute = 1; pulse(); chk("rev_down", dut.vol_cur, 499);
    Mute = 0; pulse(); chk("rev_up", dut.vol_cur, 500);
    repeat (523) pulse();
    chk("ramp_top", dut.vol_cur, 1023);

    // scaling and PWM duty
    capture(0, 16'h8000); pulse();
    chk("scale_neg", $signed(dut.scaled), -32735);
    measure(hi); chk("pwm_min", hi, 0);
    capture(0, 16'h0000); pulse();
    measure(hi); chk("pwm_mid", hi, 128);
    capture(0, 16'h7FFF); pulse();
    chk("scale_pos", $signed(dut.scaled), 32735);
    measure(hi); chk("pwm_max", hi, 255);
    Volume = 10'd512;
    repeat (511) pulse();
    chk("vol_512", dut.vol_cur, 512);
    capture(0, 16'h4000); pulse();
    chk("scale_half", $signed(dut.scaled), 8192);
    chk("scale_model", $signed(dut.scaled), m_scaled);
    measure(hi); chk("pwm_160", hi, 160);

    // duty change mid-period takes effect from the next period
    capture(0, 16'h0000); pulse();
    capture(1, 16'h7FFF);
    repeat (512) tick();
    found = 0;
    prev = PWM[0];
    for (int i = 0; i < 600 && !found; i++) begin
      tick();
      if (!prev && PWM[0]) found = 1;
      prev = PWM[0];
    end
    chk("pwm_align", 32'(found), 1);
    hi = (PWM == 2'b11) ? 1 : 0;
    for (int i = 1; i < 256; i++) begin
      if (i == 20) pulse(); else tick();
      if (PWM == 2'b11) hi++;
    end
    chk("pwm_old_period", hi, 128);
    hi = 0;
    repeat (256) begin tick(); if (PWM == 2'b11) hi++; end
    chk("pwm_new_period", hi, 191);

    // asynchronous reset mid-period with PWM high
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      tick();
      if (PWM == 2'b11) found = 1;
    end
    chk("pre_rst_pwm", PWM, 2'b11);
    chk("pre_rst_level", Level, m_level);
    #2 nReset = 0;
    #1;
    chk("arst_pwm", PWM, 0);
    chk("arst_level", Level, 0);
    chk("arst_demux", DemuxSound, 0);
    chk("arst_vol", dut.vol_cur, 0);
    Data_Clk = 0;
    m_demux = '0; m_vol = 0; m_scaled = 0; m_level = '0; m_held = 0; m_timer = 0;
    tick(); tick();
    nReset = 1;
    tick();

    // randomized run against the model
    Mute = 0; Volume = 10'd700;
    repeat (700) pulse();
    chk("rand_vol", dut.vol_cur, m_vol);
    for (int it = 0; it < 40; it++) begin
      Audio = {$urandom, $urandom, $urandom};
      capture($urandom_range(0, 15), W'($urandom));
      n = $urandom_range(1, 3);
      for (int p = 0; p < n; p++) begin
        Mute = ($urandom_range(0, 3) == 0);
        Volume = VW'($urandom);
        pulse();
        chk("rand_level", Level, m_level);
        chk("rand_scaled", $signed(dut.scaled), m_scaled);
        chk("rand_vol", dut.vol_cur, m_vol);
      end
    end

`ifdef PEAK_HOLD_EN
    // peak hold then one segment lost per HOLD+1 silent samples
    capture(0, 16'h7FFF); pulse();
    chk("hold_full", Level, 10'h3FF);
    capture(0, 16'h0000);
    repeat (HOLD) pulse();
    chk("hold_kept", Level, 10'h3FF);
    pulse(); chk("hold_drop1", Level, 10'h3FE);
    repeat (HOLD) pulse();
    chk("hold_kept2", Level, 10'h3FE);
    pulse(); chk("hold_drop2", Level, 10'h3FC);
    chk("hold_model", Level, m_level);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
